// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU/accumulator: opcodes and FSM states.
package seq_alu_pkg;

    localparam logic [2:0] OP_MUL   = 3'b000;
    localparam logic [2:0] OP_SHR   = 3'b001;
    localparam logic [2:0] OP_SHL   = 3'b010;
    localparam logic [2:0] OP_ORR   = 3'b011;
    localparam logic [2:0] OP_LOGIC = 3'b100;
    localparam logic [2:0] OP_ADD   = 3'b101;
    localparam logic [2:0] OP_SUB   = 3'b110;
    localparam logic [2:0] OP_INC   = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/seq_alu_mul.sv
// Shift-add multiplier core. A start pulse loads the operands; one partial
// product is folded in per cycle for WIDTH cycles. 'done' is high during the
// final iteration and 'prod' then already includes that last partial product,
// so the caller can capture the full result on the same edge.
module seq_alu_mul #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);
    localparam int RES_W = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [RES_W-1:0] mcand_q;
    logic [WIDTH-1:0] mult_q;
    logic [RES_W-1:0] prod_q;
    logic [CNT_W-1:0] cnt_q;
    logic [RES_W-1:0] prod_sum;

    assign prod_sum = prod_q + (mult_q[0] ? mcand_q : '0);
    assign prod     = prod_sum;
    assign done     = (cnt_q == CNT_W'(1));

    // Operand load on start, then one shift-add step per cycle while counting down.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q <= '0;
            mult_q  <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else if (start) begin
            mcand_q <= {{WIDTH{1'b0}}, a};
            mult_q  <= b;
            prod_q  <= '0;
            cnt_q   <= CNT_W'(WIDTH);
        end else if (cnt_q != '0) begin
            prod_q  <= prod_sum;
            mcand_q <= mcand_q << 1;
            mult_q  <= mult_q >> 1;
            cnt_q   <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_alu_accum.sv
// ALU/accumulator with valid/ready handshake. Seven single-cycle ops update
// acc on the accept edge; MUL runs WIDTH cycles in the shift-add core.
// Optional feature: define ALU_FLAGS_EN to add registered flag_z/flag_c.
module seq_alu_accum
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic                 acc_clr,
    output logic [2*WIDTH-1:0]   acc,
    output logic                 out_valid
`ifdef ALU_FLAGS_EN
    ,
    output logic                 flag_z,
    output logic                 flag_c
`endif
);
    localparam int RES_W = 2 * WIDTH;
    localparam logic [WIDTH:0] WIDTH_L = (WIDTH + 1)'(WIDTH);

    state_t           state_q, state_d;
    logic [RES_W-1:0] acc_q, acc_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] b;
    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic [RES_W-1:0] mul_prod;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   inc_ext;
    logic [RES_W-1:0] diff_ext;
    logic             shift_big;
    logic [RES_W-1:0] alu_res;

    assign b         = acc_q[WIDTH-1:0];
    assign in_ready  = (state_q == IDLE) & ~acc_clr;
    assign accept    = in_valid & in_ready;
    assign mul_start = accept & (op == OP_MUL);
    assign sum_ext   = {1'b0, a} + {1'b0, b};
    assign inc_ext   = {1'b0, a} + (WIDTH + 1)'(1);
    assign diff_ext  = {{WIDTH{1'b0}}, a} - {{WIDTH{1'b0}}, b};
    assign shift_big = ({1'b0, a} >= WIDTH_L);

    assign acc       = acc_q;
    assign out_valid = out_valid_q;

    seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .reset (reset),
        .start (mul_start),
        .a     (a),
        .b     (b),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    // Single-cycle datapath: result for every non-MUL opcode, zero-extended.
    always_comb begin
        alu_res = '0;
        case (op)
            OP_SHR:   alu_res = shift_big ? '0 : {{WIDTH{1'b0}}, b >> a};
            OP_SHL:   alu_res = shift_big ? '0 : {{WIDTH{1'b0}}, b << a};
            OP_ORR:   alu_res = {{(RES_W-1){1'b0}}, |{a, b}};
            OP_LOGIC: alu_res = {a ^ b, a | b};
            OP_ADD:   alu_res = {{(WIDTH-1){1'b0}}, sum_ext};
            OP_SUB:   alu_res = diff_ext;
            OP_INC:   alu_res = {{(WIDTH-1){1'b0}}, inc_ext};
            default:  alu_res = '0;
        endcase
    end

    // Next-state logic: clear beats accept in IDLE; MUL waits for the core.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc_clr) begin
                    acc_d = '0;
                end else if (accept) begin
                    if (op == OP_MUL) begin
                        state_d = MUL;
                    end else begin
                        acc_d       = alu_res;
                        out_valid_d = 1'b1;
                    end
                end
            end
            MUL: begin
                if (mul_done) begin
                    acc_d       = mul_prod;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, accumulator and result strobe registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef ALU_FLAGS_EN
    logic flag_z_q, flag_c_q;
    logic carry_d;

    // Carry/borrow of the current single-cycle op.
    always_comb begin
        carry_d = 1'b0;
        case (op)
            OP_ADD:  carry_d = sum_ext[WIDTH];
            OP_SUB:  carry_d = (a < b);
            OP_INC:  carry_d = inc_ext[WIDTH];
            default: carry_d = 1'b0;
        endcase
    end

    // Flags follow every accumulator update, including clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else if (state_q == IDLE && acc_clr) begin
            flag_z_q <= 1'b1;
            flag_c_q <= 1'b0;
        end else if (state_q == IDLE && accept && op != OP_MUL) begin
            flag_z_q <= (alu_res == '0);
            flag_c_q <= carry_d;
        end else if (state_q == MUL && mul_done) begin
            flag_z_q <= (mul_prod == '0);
            flag_c_q <= 1'b0;
        end
    end

    assign flag_z = flag_z_q;
    assign flag_c = flag_c_q;
`endif

endmodule

// File: tb/tb_seq_alu_accum.sv
// Self-checking bench for seq_alu_accum (WIDTH=4 main instance, WIDTH=8 for a wide MUL).
module tb_seq_alu_accum;
    import seq_alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, in_valid, acc_clr;
    logic [2:0] op;
    logic [3:0] a;
    wire        in_ready, out_valid;
    wire  [7:0] acc;

    logic        in_valid8, acc_clr8;
    logic [2:0]  op8;
    logic [7:0]  a8;
    wire         in_ready8, out_valid8;
    wire  [15:0] acc8;

`ifdef ALU_FLAGS_EN
    wire flag_z, flag_c, flag_z8, flag_c8;
`endif

    seq_alu_accum #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .acc_clr(acc_clr), .acc(acc), .out_valid(out_valid)
`ifdef ALU_FLAGS_EN
        , .flag_z(flag_z), .flag_c(flag_c)
`endif
    );

    seq_alu_accum #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .op(op8), .a(a8), .acc_clr(acc_clr8), .acc(acc8), .out_valid(out_valid8)
`ifdef ALU_FLAGS_EN
        , .flag_z(flag_z8), .flag_c(flag_c8)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int         pre;
        logic [2:0] op;
        logic [3:0] a;
        logic [7:0] exp;
        int         lat;
        logic       exp_c;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    // Reference behaviour from the opcode table, plain integer arithmetic (WIDTH=4).
    function automatic int model(input int o, input int av, input int bv);
        case (o)
            0: return av * bv;
            1: return (av >= 4) ? 0 : (bv >> av);
            2: return (av >= 4) ? 0 : ((bv << av) & 15);
            3: return ((av | bv) != 0) ? 1 : 0;
            4: return ((av ^ bv) << 4) | (av | bv);
            5: return av + bv;
            6: return (av - bv) & 255;
            default: return av + 1;
        endcase
    endfunction

    function automatic int model_c(input int o, input int av, input int bv);
        case (o)
            5: return (av + bv > 15) ? 1 : 0;
            6: return (av < bv) ? 1 : 0;
            7: return (av + 1 > 15) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    // Issue one op; returns acc when out_valid appears, edges waited, and in_ready-low cycles.
    task automatic issue(input logic [2:0] o, input logic [3:0] av,
                         output logic [7:0] r, output int lat, output int rdy_low);
        int g;
        g = 0;
        #1;
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("ready_wait", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        op = o;
        a = av;
        @(negedge clk);
        in_valid = 1'b0;
        op = 3'($urandom);
        a = 4'($urandom);
        lat = 0;
        rdy_low = 0;
        while (!out_valid && lat < 20) begin
            if (!in_ready) rdy_low++;
            @(negedge clk);
            lat++;
        end
        r = acc;
    endtask

    task automatic clear_acc();
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
    endtask

    // Load acc with v (0..16) via clear then INC.
    task automatic preset(input int v);
        logic [7:0] r;
        int l, rl;
        clear_acc();
        if (v > 0) issue(OP_INC, 4'(v - 1), r, l, rl);
    endtask

    initial begin
        logic [7:0] r;
        int lat, rl, mdl, e, pulses, seen;
        logic [2:0] ro;
        logic [3:0] ra;

        vecs[0]  = '{3,    OP_ADD,   4'hF, 8'h12, 0, 1'b1};
        vecs[1]  = '{13,   OP_MUL,   4'hB, 8'h8F, 4, 1'b0};
        vecs[2]  = '{6,    OP_SHL,   4'h1, 8'h0C, 0, 1'b0};
        vecs[3]  = '{6,    OP_SHR,   4'h4, 8'h00, 0, 1'b0};
        vecs[4]  = '{6,    OP_SUB,   4'h2, 8'hFC, 0, 1'b1};
        vecs[5]  = '{6,    OP_SHR,   4'h1, 8'h03, 0, 1'b0};
        vecs[6]  = '{9,    OP_SHL,   4'h3, 8'h08, 0, 1'b0};
        vecs[7]  = '{0,    OP_ORR,   4'h0, 8'h00, 0, 1'b0};
        vecs[8]  = '{0,    OP_ORR,   4'h4, 8'h01, 0, 1'b0};
        vecs[9]  = '{5,    OP_LOGIC, 4'h3, 8'h67, 0, 1'b0};
        vecs[10] = '{15,   OP_MUL,   4'hF, 8'hE1, 4, 1'b0};
        vecs[11] = '{2,    OP_SUB,   4'h7, 8'h05, 0, 1'b0};
        vecs[12] = '{0,    OP_INC,   4'hF, 8'h10, 0, 1'b1};
        vecs[13] = '{16,   OP_MUL,   4'h7, 8'h00, 4, 1'b0};

        reset = 1'b1; in_valid = 1'b0; acc_clr = 1'b0; op = 3'd0; a = 4'd0;
        in_valid8 = 1'b0; acc_clr8 = 1'b0; op8 = 3'd0; a8 = 8'd0;
        repeat (3) @(negedge clk);
        check("reset_acc", {24'b0, acc}, 32'h0);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
`ifdef ALU_FLAGS_EN
        check("reset_flag_z", {31'b0, flag_z}, 32'd0);
        check("reset_flag_c", {31'b0, flag_c}, 32'd0);
`endif
        reset = 1'b0;
        @(negedge clk);

        // Directed table
        foreach (vecs[i]) begin
            preset(vecs[i].pre);
            issue(vecs[i].op, vecs[i].a, r, lat, rl);
            $display("[TB] vec %0d op=%0d a=0x%0h acc=0x%0h lat=%0d", i, vecs[i].op, vecs[i].a, r, lat);
            check($sformatf("vec%0d_acc", i), {24'b0, r}, {24'b0, vecs[i].exp});
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_ready_low", i), rl, vecs[i].lat);
            @(negedge clk);
            check($sformatf("vec%0d_single_pulse", i), {31'b0, out_valid}, 32'd0);
`ifdef ALU_FLAGS_EN
            check($sformatf("vec%0d_flag_z", i), {31'b0, flag_z}, {31'b0, vecs[i].exp == 8'h00});
            check($sformatf("vec%0d_flag_c", i), {31'b0, flag_c}, {31'b0, vecs[i].exp_c});
`endif
        end

        // Reset in the middle of a MUL aborts it
        preset(13);
        #1;
        in_valid = 1'b1; op = OP_MUL; a = 4'hB;
        @(negedge clk);
        in_valid = 1'b0;
        check("mulrst_busy", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mulrst_acc", {24'b0, acc}, 32'h0);
        check("mulrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mulrst_in_ready", {31'b0, in_ready}, 32'd1);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mulrst_no_pulse", seen, 0);
        $display("[TB] reset mid-MUL acc=0x%0h pulses=%0d", acc, seen);

        // Clear wins over a simultaneous request
        clear_acc();
        issue(OP_LOGIC, 4'h5, r, lat, rl);
        check("clr_preset", {24'b0, r}, 32'h55);
        @(negedge clk);
        in_valid = 1'b1; acc_clr = 1'b1; op = OP_INC; a = 4'h3;
        #1;
        check("clr_in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0; acc_clr = 1'b0;
        check("clr_acc", {24'b0, acc}, 32'h0);
        check("clr_out_valid", {31'b0, out_valid}, 32'd0);
`ifdef ALU_FLAGS_EN
        check("clr_flag_z", {31'b0, flag_z}, 32'd1);
        check("clr_flag_c", {31'b0, flag_c}, 32'd0);
`endif
        @(negedge clk);
        check("clr_not_executed", {24'b0, acc}, 32'h0);
        $display("[TB] clear+valid acc=0x%0h out_valid=%0d", acc, out_valid);

        // Back-to-back INC for three cycles
        in_valid = 1'b1; op = OP_INC; a = 4'hF;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 2) in_valid = 1'b0;
            check($sformatf("b2b_acc%0d", i), {24'b0, acc}, 32'h10);
            if (out_valid) pulses++;
        end
        @(negedge clk);
        check("b2b_pulses", pulses, 3);
        check("b2b_end", {31'b0, out_valid}, 32'd0);
        $display("[TB] back-to-back INC pulses=%0d", pulses);

        // Random ops against the reference model
        clear_acc();
        mdl = 0;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                clear_acc();
                mdl = 0;
                check("rnd_clear", {24'b0, acc}, 32'h0);
                $display("[TB] rnd %0d clear", i);
            end else begin
                ro = 3'($urandom);
                ra = 4'($urandom);
                e = model(ro, ra, mdl & 15);
                issue(ro, ra, r, lat, rl);
                $display("[TB] rnd %0d op=%0d a=0x%0h B=0x%0h acc=0x%0h exp=0x%0h",
                         i, ro, ra, mdl & 15, r, e);
                check($sformatf("rnd%0d_acc", i), {24'b0, r}, e);
                check($sformatf("rnd%0d_latency", i), lat, (ro == OP_MUL) ? 4 : 0);
`ifdef ALU_FLAGS_EN
                check($sformatf("rnd%0d_flag_z", i), {31'b0, flag_z}, (e == 0) ? 1 : 0);
                check($sformatf("rnd%0d_flag_c", i), {31'b0, flag_c}, model_c(ro, ra, mdl & 15));
`endif
                mdl = e;
            end
        end

        // WIDTH=8: 0xFF * 0xFF
        @(negedge clk);
        in_valid8 = 1'b1; op8 = OP_INC; a8 = 8'hFE;
        @(negedge clk);
        in_valid8 = 1'b0;
        check("w8_preset", {16'b0, acc8}, 32'hFF);
        in_valid8 = 1'b1; op8 = OP_MUL; a8 = 8'hFF;
        @(negedge clk);
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check("w8_mul_acc", {16'b0, acc8}, 32'hFE01);
        check("w8_mul_latency", lat, 8);
        $display("[TB] W8 MUL acc=0x%0h lat=%0d", acc8, lat);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
